// File: rtl/addsub_unit.sv
// Two-stage add/subtract pipeline with a sign-magnitude result and a carry/borrow chain
// register, so that ADDC/SUBB sequences can extend arithmetic across several operations.
module addsub_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s,
    output logic [WIDTH:0]   out,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam logic [OPW-1:0] OpAdd  = OPW'(1);
    localparam logic [OPW-1:0] OpSub  = OPW'(2);
    localparam logic [OPW-1:0] OpCmp  = OPW'(3);
    localparam logic [OPW-1:0] OpAddc = OPW'(4);
    localparam logic [OPW-1:0] OpSubb = OPW'(5);

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OPW-1:0]   op_q;
    logic             s2_valid_q;
    logic             cy_q, cy_d;
    logic [WIDTH:0]   out_q;
    logic             s_q, zero_q, carry_q, err_q;

    logic             s1_take, s2_take;
    logic [WIDTH:0]   a_ext, b_ext, cy_ext, raw, raw_neg;
    logic [WIDTH:0]   res_out;
    logic             res_s, res_carry, res_err;

    assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
    assign s1_take  = in_valid && in_ready;
    assign s2_take  = s1_valid_q && (!s2_valid_q || out_ready);

    assign a_ext   = {1'b0, a_q};
    assign b_ext   = {1'b0, b_q};
    assign cy_ext  = {{WIDTH{1'b0}}, cy_q};
    assign raw_neg = ~raw + 1'b1;

    always_comb begin
        raw       = '0;
        res_out   = '0;
        res_s     = 1'b0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        cy_d      = cy_q;
        case (op_q)
            OpAdd, OpAddc: begin
                raw       = (op_q == OpAddc) ? (a_ext + b_ext + cy_ext) : (a_ext + b_ext);
                res_out   = raw;
                res_carry = raw[WIDTH];
                cy_d      = raw[WIDTH];
            end
            OpSub, OpCmp, OpSubb: begin
                raw       = (op_q == OpSubb) ? (a_ext - b_ext - cy_ext) : (a_ext - b_ext);
                res_s     = raw[WIDTH];
                res_out   = raw[WIDTH] ? raw_neg : raw;
                res_carry = raw[WIDTH];
                // CMP only reports; it must not disturb a pending borrow chain
                if (op_q != OpCmp) begin
                    cy_d = raw[WIDTH];
                end
            end
            default: begin
                res_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            cy_q       <= 1'b0;
            out_q      <= '0;
            s_q        <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (s1_take) begin
                s1_valid_q <= 1'b1;
                a_q        <= a;
                b_q        <= b;
                op_q       <= op;
            end else if (s2_take) begin
                s1_valid_q <= 1'b0;
            end

            if (s2_take) begin
                s2_valid_q <= 1'b1;
                cy_q       <= cy_d;
                out_q      <= res_out;
                s_q        <= res_s;
                zero_q     <= (res_out == '0);
                carry_q    <= res_carry;
                err_q      <= res_err;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign s         = s_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_addsub_unit.sv
// Directed bench for addsub_unit (WIDTH = 4): a vector table applied one operation at a time,
// followed by hand-written latency, back-to-back, back-pressure and mid-stream reset sequences.
module tb_addsub_unit;

    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] CMP  = 4'd3;
    localparam logic [3:0] ADDC = 4'd4;
    localparam logic [3:0] SUBB = 4'd5;

    typedef struct packed {
        logic       s;
        logic [4:0] out;
        logic       zero;
        logic       carry;
        logic       err;
    } res_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] a, b, op;
    logic       out_valid, out_ready;
    logic       s, zero, carry, err;
    logic [4:0] out;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t got_q[$];
    vec_t vecs[20];

    addsub_unit #(.WIDTH(4), .OPW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Every result actually handed to the consumer, in delivery order
    always @(posedge clk) begin
        if (out_valid && out_ready) got_q.push_back({s, out, zero, carry, err});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [3:0] o, logic [3:0] x, logic [3:0] y, logic es,
                                logic [4:0] eo, logic ez, logic ec, logic ee);
        vec_t v;
        v.op  = o;
        v.a   = x;
        v.b   = y;
        v.exp = {es, eo, ez, ec, ee};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_res(input string name, input res_t got, input res_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got s=%0b out=%0d zero=%0b carry=%0b err=%0b, required s=%0b out=%0d zero=%0b carry=%0b err=%0b",
                     name, got.s, got.out, got.zero, got.carry, got.err,
                     exp.s, exp.out, exp.zero, exp.carry, exp.err);
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge
    task automatic send(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
        bit acc = 1'b0;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        for (int t = 0; t < 20 && !acc; t++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
    endtask

    task automatic expect_res(input string name, input res_t exp);
        for (int t = 0; t < 20 && got_q.size() == 0; t++) @(negedge clk);
        if (got_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no result, required one", name);
        end else begin
            check_res(name, got_q.pop_front(), exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(SUB,   4'd3,  4'd5,  1'b1, 5'd2,  1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(ADD,   4'd15, 4'd15, 1'b0, 5'd30, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(ADDC,  4'd0,  4'd0,  1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(ADD,   4'd8,  4'd7,  1'b0, 5'd15, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(SUBB,  4'd0,  4'd15, 1'b1, 5'd15, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(SUBB,  4'd0,  4'd15, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(CMP,   4'd7,  4'd7,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(ADDC,  4'd1,  4'd2,  1'b0, 5'd4,  1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(SUB,   4'd0,  4'd1,  1'b1, 5'd1,  1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(4'd9,  4'd3,  4'd4,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1);
        vecs[10] = mk(ADDC,  4'd0,  4'd0,  1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        vecs[11] = mk(ADD,   4'd5,  4'd6,  1'b0, 5'd11, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(SUB,   4'd5,  4'd5,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
        vecs[13] = mk(4'd0,  4'd1,  4'd1,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1);
        vecs[14] = mk(SUB,   4'd9,  4'd2,  1'b0, 5'd7,  1'b0, 1'b0, 1'b0);
        vecs[15] = mk(CMP,   4'd2,  4'd9,  1'b1, 5'd7,  1'b0, 1'b1, 1'b0);
        vecs[16] = mk(ADDC,  4'd15, 4'd0,  1'b0, 5'd15, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(ADDC,  4'd15, 4'd1,  1'b0, 5'd16, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(SUBB,  4'd15, 4'd15, 1'b1, 5'd1,  1'b0, 1'b1, 1'b0);
        vecs[19] = mk(ADDC,  4'd0,  4'd0,  1'b0, 5'd1,  1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'({out_valid, in_ready, s, out, zero, carry, err}), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Vector table, one operation in flight at a time
        for (int i = 0; i < 20; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            expect_res($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Latency: result visible exactly one edge after the acceptance edge
        send(SUB, 4'd3, 4'd5);
        check("lat_after_accept_edge", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_after_second_edge", 32'(out_valid), 32'd1);
        expect_res("lat_sub_3_5", {1'b1, 5'd2, 1'b0, 1'b1, 1'b0});

        // Back-to-back carry chain
        send(ADD, 4'd15, 4'd15);
        send(ADDC, 4'd0, 4'd0);
        expect_res("b2b_add", {1'b0, 5'd30, 1'b0, 1'b1, 1'b0});
        expect_res("b2b_addc", {1'b0, 5'd1, 1'b0, 1'b0, 1'b0});

        // Back-pressure: out_ready low for three cycles under continuous input
        begin
            int k = 0;
            logic [3:0] vals[4];
            vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3; vals[3] = 4'd4;
            for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
                bit acc;
                out_ready = (cyc >= 3);
                in_valid  = 1'b1;
                op = ADD;
                a  = vals[k];
                b  = vals[k];
                #1;
                acc = in_ready;
                if (cyc == 2) begin
                    check("stall_in_ready_low", 32'(in_ready), 32'd0);
                    check("stall_out_c2", 32'({out_valid, out}), 32'({1'b1, 5'd2}));
                end
                if (cyc == 3) check("stall_out_c3", 32'({out_valid, out}), 32'({1'b1, 5'd2}));
                @(posedge clk);
                if (acc) k++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            check("stall_all_accepted", 32'(k), 32'd4);
            expect_res("stall_r0", {1'b0, 5'd2, 1'b0, 1'b0, 1'b0});
            expect_res("stall_r1", {1'b0, 5'd4, 1'b0, 1'b0, 1'b0});
            expect_res("stall_r2", {1'b0, 5'd6, 1'b0, 1'b0, 1'b0});
            expect_res("stall_r3", {1'b0, 5'd8, 1'b0, 1'b0, 1'b0});
            repeat (4) @(negedge clk);
            check("stall_no_duplicates", 32'(got_q.size()), 32'd0);
        end

        // Mid-stream reset with both stages full; the SUB in S2 has set cy
        out_ready = 1'b0;
        send(SUB, 4'd0, 4'd1);
        send(ADD, 4'd1, 4'd1);
        check("rst_pre_full", 32'({out_valid, in_ready}), 32'({1'b1, 1'b0}));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 32'({out_valid, in_ready, s, out, zero, carry, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("rst_no_stale", 32'(got_q.size()), 32'd0);
        send(ADDC, 4'd0, 4'd0);
        expect_res("rst_cy_cleared", {1'b0, 5'd0, 1'b1, 1'b0, 1'b0});

        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(got_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
